// File: rtl/lane_vote_deser_if.sv
// lane_vote_deser_if: word output handshake of the lane-vote deserializer.
// master drives data/valid, slave drives ready.
interface lane_vote_deser_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] o_data;
   logic              o_valid;
   logic              i_ready;

   modport master (
      output o_data,
      output o_valid,
      input  i_ready
   );

   modport slave (
      input  o_data,
      input  o_valid,
      output i_ready
   );
endinterface

// File: rtl/lane_vote_deser.sv
// lane_vote_deser: majority-votes a replicated lane bus, flags lane
// disagreement, and deserializes voted bits MSB-first into a 2-entry FIFO.
module lane_vote_deser #(
   parameter int LANES  = 8,
   parameter int DATA_W = 8,
   parameter int ERR_W  = 16
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [LANES-1:0]   i_x,
   input  logic               i_en,
   lane_vote_deser_if.master  bus,
   output logic               o_mismatch,
   output logic [ERR_W-1:0]   o_err_cnt,
   output logic               o_overflow
);

   localparam int PW = $clog2(LANES + 1);
   localparam int CW = $clog2(DATA_W);
   localparam logic [PW-1:0] HALF = PW'(LANES / 2);
   localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

   typedef enum logic [1:0] {
      S_EMPTY,
      S_ONE,
      S_FULL
   } fifo_st_t;

   fifo_st_t            state, state_d;
   logic [DATA_W-1:0]   ent0, ent0_d;
   logic [DATA_W-1:0]   ent1, ent1_d;
   logic                ovf_d;

   logic [PW-1:0]       pop;
   logic                vote;
   logic                mism;
   logic [CW-1:0]       cnt;
   logic [DATA_W-2:0]   sreg;
   logic [DATA_W-1:0]   word;
   logic                push;
   logic                deq;

   // Population count of the lane bus
   always_comb begin
      pop = '0;
      for (int i = 0; i < LANES; i++) begin
         pop = pop + PW'(i_x[i]);
      end
   end

   // Majority vote; a tie falls back to lane 0
   always_comb begin
      vote = i_x[0];
      unique case (1'b1)
         (pop > HALF):  vote = 1'b1;
         (pop < HALF):  vote = 1'b0;
         (pop == HALF): vote = i_x[0];
      endcase
   end

   assign mism = (|i_x) && !(&i_x);
   assign word = {sreg, vote};
   assign push = i_en && (cnt == LAST);
   assign deq  = bus.o_valid && bus.i_ready;

   // Mismatch flag and saturating disagreement counter
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_mismatch <= 1'b0;
         o_err_cnt  <= '0;
      end else if (i_en) begin
         o_mismatch <= mism;
         if (mism && (o_err_cnt != '1)) begin
            o_err_cnt <= o_err_cnt + ERR_W'(1);
         end
      end
   end

   // Bit counter and shift register; only the low DATA_W-1 bits are kept
   // because the MSB of the full register is never read
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt  <= '0;
         sreg <= '0;
      end else if (i_en) begin
         sreg <= word[DATA_W-2:0];
         if (cnt == LAST) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   // FIFO state, entries and sticky overflow
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= S_EMPTY;
         ent0       <= '0;
         ent1       <= '0;
         o_overflow <= 1'b0;
      end else begin
         state      <= state_d;
         ent0       <= ent0_d;
         ent1       <= ent1_d;
         o_overflow <= ovf_d;
      end
   end

   // FIFO next state: ent0 is always the head
   always_comb begin
      state_d = state;
      ent0_d  = ent0;
      ent1_d  = ent1;
      ovf_d   = o_overflow;
      case (state)
         S_EMPTY: begin
            if (push) begin
               state_d = S_ONE;
               ent0_d  = word;
            end
         end
         S_ONE: begin
            if (push && deq) begin
               ent0_d = word;
            end else if (push) begin
               state_d = S_FULL;
               ent1_d  = word;
            end else if (deq) begin
               state_d = S_EMPTY;
            end
         end
         S_FULL: begin
            if (push && deq) begin
               ent0_d = ent1;
               ent1_d = word;
            end else if (deq) begin
               state_d = S_ONE;
               ent0_d  = ent1;
            end else if (push) begin
               ovf_d = 1'b1;
            end
         end
         default: begin
            state_d = S_EMPTY;
         end
      endcase
   end

   assign bus.o_valid = (state != S_EMPTY);
   assign bus.o_data  = ent0;

endmodule

// File: tb/tb_lane_vote_deser.sv
// tb_lane_vote_deser: scoreboard bench for lane_vote_deser.
// Expected words are queued on stimulus and checked on each handshake.
module tb_lane_vote_deser;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  x;
   logic        en;
   logic        mism, ovf;
   logic [15:0] errc;
   logic        mism2, ovf2;
   logic [1:0]  errc2;
   bit          tog;

   int          n_run = 0;
   int          n_fail = 0;
   logic [7:0]  q[$];

   always #5 clk = ~clk;

   lane_vote_deser_if #(.DATA_W(8)) bus ();
   lane_vote_deser_if #(.DATA_W(8)) bus2 ();

   assign bus2.i_ready = 1'b1;

   lane_vote_deser #(
      .LANES (8),
      .DATA_W(8),
      .ERR_W (16)
   ) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_x       (x),
      .i_en      (en),
      .bus       (bus.master),
      .o_mismatch(mism),
      .o_err_cnt (errc),
      .o_overflow(ovf)
   );

   lane_vote_deser #(
      .LANES (8),
      .DATA_W(8),
      .ERR_W (2)
   ) dut2 (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_x       (x),
      .i_en      (en),
      .bus       (bus2.master),
      .o_mismatch(mism2),
      .o_err_cnt (errc2),
      .o_overflow(ovf2)
   );

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_run++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step(logic [7:0] xv, logic ev);
      x  = xv;
      en = ev;
      if (tog) bus.i_ready = ~bus.i_ready;
      @(posedge clk);
      #1;
   endtask

   task automatic send(logic [7:0] w, int gap, bit exp_push, bit rdy_last);
      for (int b = 7; b >= 0; b--) begin
         if (b == 0 && exp_push) q.push_back(w);
         if (b == 0 && rdy_last) bus.i_ready = 1'b1;
         step(w[b] ? 8'hFF : 8'h00, 1'b1);
         for (int g = 0; g < gap; g++) step(8'h00, 1'b0);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(8'h00, 1'b0);
      rst = 1'b0;
      q.delete();
   endtask

   task automatic drain();
      bus.i_ready = 1'b1;
      for (int i = 0; i < 50 && q.size() != 0; i++) step(8'h00, 1'b0);
      chk("drain", q.size(), 0);
   endtask

   // Scoreboard: compare every accepted word with the oldest expectation
   always @(negedge clk) begin
      if (!rst && bus.o_valid && bus.i_ready) begin
         if (q.size() == 0) chk("spurious", q.size(), 1);
         else chk("word", bus.o_data, q.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] xs [8];
      logic       me [8];
      logic [1:0] se [5];

      rst = 1'b1;
      x = 8'h00;
      en = 1'b0;
      tog = 1'b0;
      bus.i_ready = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_valid", bus.o_valid, 0);
      chk("rst_data", bus.o_data, 0);
      chk("rst_mism", mism, 0);
      chk("rst_err", errc, 0);
      chk("rst_ovf", ovf, 0);

      // Clean word 0xA5
      bus.i_ready = 1'b1;
      send(8'hA5, 0, 1'b1, 1'b0);
      chk("a5_valid", bus.o_valid, 1);
      chk("a5_data", bus.o_data, 8'hA5);
      chk("a5_mism", mism, 0);
      chk("a5_err", errc, 0);
      drain();

      // Vote with disagreeing lanes and a tie
      xs = '{8'hE0, 8'h1F, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      me = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 8; i++) begin
         if (i == 7) q.push_back(8'h60);
         step(xs[i], 1'b1);
         chk("vote_mism", mism, me[i]);
      end
      chk("vote_err", errc, 3);
      drain();

      // Overflow: third word dropped while stalled
      bus.i_ready = 1'b0;
      send(8'h11, 0, 1'b1, 1'b0);
      send(8'h22, 0, 1'b1, 1'b0);
      send(8'h33, 0, 1'b0, 1'b0);
      chk("ovf_valid", bus.o_valid, 1);
      chk("ovf_head", bus.o_data, 8'h11);
      chk("ovf_flag", ovf, 1);
      drain();
      chk("ovf_empty", bus.o_valid, 0);
      chk("ovf_sticky", ovf, 1);

      // Full with simultaneous pop and push keeps both
      do_reset();
      bus.i_ready = 1'b0;
      send(8'h44, 0, 1'b1, 1'b0);
      send(8'h55, 0, 1'b1, 1'b0);
      send(8'h66, 0, 1'b1, 1'b1);
      bus.i_ready = 1'b0;
      step(8'h00, 1'b0);
      chk("fpp_valid", bus.o_valid, 1);
      chk("fpp_head", bus.o_data, 8'h55);
      chk("fpp_ovf", ovf, 0);
      drain();

      // Continuous words with ready toggling every cycle
      bus.i_ready = 1'b1;
      tog = 1'b1;
      send(8'hA1, 0, 1'b1, 1'b0);
      send(8'hB2, 0, 1'b1, 1'b0);
      send(8'hC3, 0, 1'b1, 1'b0);
      send(8'hD4, 0, 1'b1, 1'b0);
      tog = 1'b0;
      drain();
      chk("tog_ovf", ovf, 0);

      // Gapped sampling, then reset mid-word
      send(8'hC3, 3, 1'b1, 1'b0);
      drain();
      for (int i = 0; i < 4; i++) step(8'hFF, 1'b1);
      rst = 1'b1;
      step(8'hFF, 1'b1);
      rst = 1'b0;
      chk("mid_valid", bus.o_valid, 0);
      chk("mid_data", bus.o_data, 0);
      chk("mid_mism", mism, 0);
      chk("mid_err", errc, 0);
      chk("mid_ovf", ovf, 0);
      send(8'h5A, 0, 1'b1, 1'b0);
      chk("clean_data", bus.o_data, 8'h5A);
      drain();

      // Saturating counter on the narrow instance
      do_reset();
      se = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      for (int i = 0; i < 5; i++) begin
         step(8'h0F, 1'b1);
         chk("sat_cnt", errc2, se[i]);
         chk("sat_mism", mism2, 1);
      end
      chk("wide_cnt", errc, 5);
      do_reset();
      chk("sat_rst", errc2, 0);
      chk("ovf2", ovf2, 0);

      chk("q_empty", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
